imem_loader: RTL and testbench
==============================

# imem_loader

Instruction-side responder for the single-cycle `cpu` core. It answers the core's fetch address (`o_pc`) with an instruction word every cycle, and it owns a byte-stream program loader that fills instruction RAM from a host link such as a UART receiver. The block holds the core in reset until a complete, well-formed image has been written, then releases it to run from address 0.

## Interface
- `DEPTH_WORDS`, default 512: instruction RAM depth in 32-bit words. Must be a power of two, at least 4.
- `i_clk`, input, 1: system clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_pc`, input, 32: fetch address, driven from the core's `o_pc`.
- `o_inst`, output, 32: instruction word, driven to the core's `i_inst`.
- `o_fetch_fault`, output, 1: current fetch is misaligned or out of range.
- `i_load_start`, input, 1: single-cycle pulse that starts (or restarts) a load.
- `i_byte_valid`, input, 1: host byte is valid.
- `i_byte_data`, input, 8: host byte.
- `o_byte_ready`, output, 1: loader accepts a byte this cycle.
- `o_cpu_rst_n`, output, 1: active-low reset to the core; registered.
- `o_load_done`, output, 1: image loaded and the core is running; registered.
- `o_load_error`, output, 1: header rejected; registered.

## Operation
- **States**
  - IDLE: the reset state.
  - LEN: receiving the 4-byte header.
  - DATA: receiving the image.
  - RUN: image loaded, core running.
  - ERR: header rejected.
- **Transitions**
  - `i_load_start` from any state goes to LEN, clearing the byte and word counters. This includes aborting an in-progress LEN or DATA.
  - LEN receives 4 bytes, little-endian, forming word count N.
  - On the 4th header byte: N==0 or N>DEPTH_WORDS goes to ERR; otherwise goes to DATA.
  - DATA receives 4*N bytes, assembled little-endian: the first byte is bits [7:0].
  - On each 4th byte of a word, RAM[word_idx] is written and word_idx increments.
  - After word N-1 is written, the state goes to RUN.
  - ERR and RUN hold until `i_load_start` or reset.
- **Handshake**
  - `o_byte_ready` = (state is LEN or DATA) && !`i_load_start`.
  - A byte transfers only on a rising edge where `i_byte_valid` && `o_byte_ready`.
  - The host may hold `i_byte_valid` for any length of time; no byte is lost or duplicated.
- **Outputs by state**
  - `o_cpu_rst_n` = 1 only in RUN.
  - `o_load_done` = 1 only in RUN.
  - `o_load_error` = 1 only in ERR.
  - All three are registered from the next-state value, so they change on the same edge as the state.
- **Fetch**
  - `o_inst` is combinational: RAM[`i_pc`[log2(DEPTH_WORDS)+1:2]].
  - If `i_pc`[1:0] != 0 or `i_pc` >= 4*DEPTH_WORDS, then `o_inst` = 32'h00000013 (nop) and `o_fetch_fault` = 1. Otherwise `o_fetch_fault` = 0.
  - Fetch is served in every state. The core ignores it while in reset.
- **RAM contents**
  - RAM is not cleared by reset or by a new load.
  - Words at index N and above keep their previous contents.

## Timing
- **Reset values:** state IDLE, counters 0, `o_cpu_rst_n`=0, `o_load_done`=0, `o_load_error`=0.
- **Reset output timing**
  - `o_byte_ready`=0 while reset is asserted.
  - `o_inst` and `o_fetch_fault` follow `i_pc` combinationally at all times.
- **Write latency:** the RAM write commits on the edge that accepts the 4th byte of a word. The new word is visible on `o_inst` immediately after that edge.
- **Core release:** `o_cpu_rst_n` rises on the same edge that writes the last word. The core's first fetch (pc 0) therefore sees the complete image.
- **Load latency:** with valid held high, 4 + 4N accepted bytes take exactly 4 + 4N cycles after the start pulse.
- **Restart from RUN:** `i_load_start` in RUN drops `o_cpu_rst_n` on the next edge. The core is held in reset for the whole reload.
- **Simultaneous start and valid byte:** start wins, and the byte is not accepted (ready is 0).
- **Asynchronous reset mid-load:** the state returns to IDLE immediately and `o_cpu_rst_n`=0. A partially assembled word is discarded and not written.
- **Maximum image:** N == DEPTH_WORDS is legal. word_idx must not wrap before the final write.

## Test plan
- **Basic load:** reset, start, header 02 00 00 00, data b3 80 82 01 13 00 00 00.
  - RAM[0]=32'h018280b3 and RAM[1]=32'h00000013.
  - `o_cpu_rst_n` rises on the edge of the 12th byte.
  - `i_pc`=4 gives `o_inst`=32'h00000013.
- **Backpressure:** same image with `i_byte_valid` toggled randomly.
  - Identical RAM contents.
  - No byte accepted while `o_byte_ready`=0, and no duplicates.
- **Bad header:** header 00 00 00 00.
  - ERR; `o_load_error`=1; `o_cpu_rst_n` stays 0.
  - Repeat with N=DEPTH_WORDS+1: also ERR.
- **Abort and reload:** start, header N=3, 5 data bytes, then start again, header N=1, data ef be ad de.
  - RAM[0]=32'hdeadbeef; RUN after 8 bytes of the second load.
  - Repeat the reload from RUN: `o_cpu_rst_n` drops the next edge.
- **Fetch faults:** `i_pc`=32'h2 and `i_pc`=4*DEPTH_WORDS.
  - `o_inst`=32'h00000013 and `o_fetch_fault`=1.
  - `i_pc`=0 gives `o_fetch_fault`=0.
- **Reset mid-word:** assert `i_rst_n` low after 2 data bytes of a word.
  - IDLE immediately; that RAM word is unchanged.
  - `o_cpu_rst_n`=0 and `o_byte_ready`=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: instruction-side responder and byte-stream program loader.
// A host streams a 4-byte little-endian word count N, then 4*N image bytes.
// The core is held in reset until the last word is written. Fetches are
// served from the same RAM in every state.
module imem_loader #(
   parameter int DEPTH_WORDS = 512
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_pc,
   output logic [31:0] o_inst,
   output logic        o_fetch_fault,
   input  logic        i_load_start,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte_data,
   output logic        o_byte_ready,
   output logic        o_cpu_rst_n,
   output logic        o_load_done,
   output logic        o_load_error
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);
   localparam logic [31:0] PC_LIMIT = 32'(4 * DEPTH_WORDS);
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_RUN  = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   // One extra bit so an image of exactly DEPTH_WORDS words never wraps.
   logic [AW:0] word_idx_q, word_idx_d;
   logic [31:0] len_q, len_d;
   // Holds the three most recent bytes of the word being assembled,
   // oldest byte in the low lane.
   logic [23:0] asm_q, asm_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        load_done_q, load_done_d;
   logic        load_error_q, load_error_d;

   logic          byte_ready_s;
   logic          accept_s;
   logic [31:0]   full_word_s;
   logic [31:0]   words_written_s;
   logic          mem_we_s;
   logic [AW-1:0] mem_waddr_s;
   logic [31:0]   mem_wdata_s;

   // Instruction RAM; deliberately not reset so old words survive reloads.
   logic [31:0] ram_q [DEPTH_WORDS];

   // Loader is ready in the receive states, except when a start pulse
   // is present (the restart takes priority over the byte).
   always_comb begin
      byte_ready_s = 1'b0;
      if (((state_q == ST_LEN) || (state_q == ST_DATA)) && !i_load_start) begin
         byte_ready_s = 1'b1;
      end else begin
         byte_ready_s = 1'b0;
      end
   end

   assign accept_s        = byte_ready_s && i_byte_valid;
   assign full_word_s     = {i_byte_data, asm_q};
   assign words_written_s = 32'(word_idx_q) + 32'd1;

   // Next-state, counter and RAM-write decode for the loader.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      len_d       = len_q;
      asm_d       = asm_q;
      mem_we_s    = 1'b0;
      mem_waddr_s = word_idx_q[AW-1:0];
      mem_wdata_s = full_word_s;

      if (i_load_start) begin
         state_d    = ST_LEN;
         byte_cnt_d = 2'd0;
         word_idx_d = '0;
         len_d      = 32'd0;
         asm_d      = 24'd0;
      end else begin
         case (state_q)
            ST_LEN: begin
               if (accept_s) begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  asm_d      = {i_byte_data, asm_q[23:8]};
                  if (byte_cnt_q == 2'd3) begin
                     len_d = full_word_s;
                     if ((full_word_s == 32'd0) || (full_word_s > DEPTH_L)) begin
                        state_d = ST_ERR;
                     end else begin
                        state_d = ST_DATA;
                     end
                  end else begin
                     state_d = ST_LEN;
                  end
               end else begin
                  state_d = ST_LEN;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  asm_d      = {i_byte_data, asm_q[23:8]};
                  if (byte_cnt_q == 2'd3) begin
                     mem_we_s   = 1'b1;
                     word_idx_d = word_idx_q + {{AW{1'b0}}, 1'b1};
                     if (words_written_s == len_q) begin
                        state_d = ST_RUN;
                     end else begin
                        state_d = ST_DATA;
                     end
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_IDLE: state_d = ST_IDLE;
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Status outputs are decoded from the next state so they move on the
   // same edge as the state register.
   always_comb begin
      cpu_rst_n_d  = 1'b0;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
      case (state_d)
         ST_RUN: begin
            cpu_rst_n_d = 1'b1;
            load_done_d = 1'b1;
         end
         ST_ERR: begin
            load_error_d = 1'b1;
         end
         default: begin
            cpu_rst_n_d  = 1'b0;
            load_done_d  = 1'b0;
            load_error_d = 1'b0;
         end
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= 2'd0;
         word_idx_q   <= '0;
         len_q        <= 32'd0;
         asm_q        <= 24'd0;
         cpu_rst_n_q  <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_idx_q   <= word_idx_d;
         len_q        <= len_d;
         asm_q        <= asm_d;
         cpu_rst_n_q  <= cpu_rst_n_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
      end
   end

   // RAM write port; commits on the edge that accepts the 4th byte of a word.
   always_ff @(posedge i_clk) begin
      if (mem_we_s) begin
         ram_q[mem_waddr_s] <= mem_wdata_s;
      end
   end

   // Combinational fetch; misaligned or out-of-range addresses return a nop.
   always_comb begin
      o_fetch_fault = 1'b0;
      o_inst        = NOP_INST;
      if ((i_pc[1:0] != 2'b00) || (i_pc >= PC_LIMIT)) begin
         o_fetch_fault = 1'b1;
         o_inst        = NOP_INST;
      end else begin
         o_fetch_fault = 1'b0;
         o_inst        = ram_q[i_pc[AW+1:2]];
      end
   end

   assign o_byte_ready = byte_ready_s;
   assign o_cpu_rst_n  = cpu_rst_n_q;
   assign o_load_done  = load_done_q;
   assign o_load_error = load_error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a table-driven basic load, hand-written corner
// sequences and randomized loads, all checked against a byte-queue model.
module tb_imem_loader;

   localparam int          DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        i_clk;
   logic        i_rst_n;
   logic [31:0] i_pc;
   logic [31:0] o_inst;
   logic        o_fetch_fault;
   logic        i_load_start;
   logic        i_byte_valid;
   logic [7:0]  i_byte_data;
   logic        o_byte_ready;
   logic        o_cpu_rst_n;
   logic        o_load_done;
   logic        o_load_error;

   imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_pc          (i_pc),
      .o_inst        (o_inst),
      .o_fetch_fault (o_fetch_fault),
      .i_load_start  (i_load_start),
      .i_byte_valid  (i_byte_valid),
      .i_byte_data   (i_byte_data),
      .o_byte_ready  (o_byte_ready),
      .o_cpu_rst_n   (o_cpu_rst_n),
      .o_load_done   (o_load_done),
      .o_load_error  (o_load_error)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: status 0 idle, 1 loading, 2 running, 3 rejected.
   int          m_status = 0;
   logic [7:0]  m_q[$];
   logic [31:0] m_n = 32'd0;
   logic [31:0] ref_mem [DEPTH];
   bit          ref_known [DEPTH];

   typedef struct {
      logic       st;
      logic       v;
      logic [7:0] d;
      logic       rdy;
      logic       rst_n;
      logic       done;
      logic       err;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        fault;
   } fvec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model: every accepted byte is appended to the stream since the last start.
   task automatic model_byte(input logic [7:0] d);
      int n;
      int k;
      logic [31:0] hdr;
      m_q.push_back(d);
      n = m_q.size();
      if (n == 4) begin
         hdr = {m_q[3], m_q[2], m_q[1], m_q[0]};
         if (hdr == 32'd0 || hdr > 32'(DEPTH)) m_status = 3;
         else m_n = hdr;
      end else if (n > 4 && (n % 4) == 0) begin
         k = (n - 4) / 4 - 1;
         ref_mem[k]   = {m_q[n-1], m_q[n-2], m_q[n-3], m_q[n-4]};
         ref_known[k] = 1'b1;
         if (k == int'(m_n) - 1) m_status = 2;
      end
   endtask

   // One clock: drive, check ready mid-cycle, advance model, check status.
   task automatic step(input logic st, input logic v, input logic [7:0] d,
                       output logic acc, output logic rdy);
      logic exp_r;
      i_load_start = st;
      i_byte_valid = v;
      i_byte_data  = d;
      @(negedge i_clk);
      rdy   = o_byte_ready;
      exp_r = (m_status == 1) && !st && i_rst_n;
      chk("byte_ready", 32'(rdy), 32'(exp_r));
      acc = v && exp_r;
      @(posedge i_clk);
      if (!i_rst_n) begin
         m_status = 0;
         m_q.delete();
      end else if (st) begin
         m_status = 1;
         m_q.delete();
      end else if (acc) begin
         model_byte(d);
      end
      #1;
      i_load_start = 1'b0;
      i_byte_valid = 1'b0;
      chk("cpu_rst_n", 32'(o_cpu_rst_n), 32'(m_status == 2));
      chk("load_done", 32'(o_load_done), 32'(m_status == 2));
      chk("load_error", 32'(o_load_error), 32'(m_status == 3));
   endtask

   task automatic check_fetch(input logic [31:0] pc);
      logic fault_e;
      int   idx;
      i_pc = pc;
      #1;
      fault_e = (pc[1:0] != 2'b00) || (pc >= 32'(4 * DEPTH));
      chk("fetch_fault", 32'(o_fetch_fault), 32'(fault_e));
      if (fault_e) begin
         chk("fetch_nop", o_inst, NOP);
      end else begin
         idx = int'(pc >> 2);
         if (ref_known[idx]) chk("fetch_inst", o_inst, ref_mem[idx]);
      end
   endtask

   task automatic send(input logic [7:0] b);
      logic acc, rdy;
      step(1'b0, 1'b1, b, acc, rdy);
   endtask

   task automatic start_load();
      logic acc, rdy;
      step(1'b1, 1'b0, 8'h00, acc, rdy);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [14];
      fvec_t       ftbl [6];
      logic [7:0]  stream[$];
      logic [31:0] hdr;
      logic        acc, rdy, v;
      int          idx, budget, r;

      for (int i = 0; i < DEPTH; i++) begin
         ref_mem[i]   = 32'd0;
         ref_known[i] = 1'b0;
      end

      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 8'hb3, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

      ftbl[0] = '{32'h0000_0000, 32'h0182_80b3, 1'b0};
      ftbl[1] = '{32'h0000_0004, 32'h0000_0013, 1'b0};
      ftbl[2] = '{32'h0000_0002, 32'h0000_0013, 1'b1};
      ftbl[3] = '{32'(4 * DEPTH), 32'h0000_0013, 1'b1};
      ftbl[4] = '{32'hffff_fffc, 32'h0000_0013, 1'b1};
      ftbl[5] = '{32'h0000_0001, 32'h0000_0013, 1'b1};

      // Reset state
      i_rst_n = 1'b0; i_pc = 32'd0; i_load_start = 1'b0;
      i_byte_valid = 1'b1; i_byte_data = 8'h00;
      @(posedge i_clk); @(negedge i_clk);
      chk("rst_byte_ready", 32'(o_byte_ready), 32'd0);
      chk("rst_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
      chk("rst_load_done", 32'(o_load_done), 32'd0);
      chk("rst_load_error", 32'(o_load_error), 32'd0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1; i_byte_valid = 1'b0;

      // Basic load from table
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].st, tbl[i].v, tbl[i].d, acc, rdy);
         chk("tbl_ready", 32'(rdy), 32'(tbl[i].rdy));
         chk("tbl_cpu_rst_n", 32'(o_cpu_rst_n), 32'(tbl[i].rst_n));
         chk("tbl_done", 32'(o_load_done), 32'(tbl[i].done));
         chk("tbl_error", 32'(o_load_error), 32'(tbl[i].err));
      end
      for (int i = 0; i < 6; i++) begin
         i_pc = ftbl[i].pc;
         #1;
         chk("ftbl_inst", o_inst, ftbl[i].inst);
         chk("ftbl_fault", 32'(o_fetch_fault), 32'(ftbl[i].fault));
      end

      // Bad headers: N == 0 and N == DEPTH+1
      start_load();
      send(8'h00); send(8'h00); send(8'h00);
      chk("bad0_not_yet", 32'(o_load_error), 32'd0);
      send(8'h00);
      chk("bad0_error", 32'(o_load_error), 32'd1);
      chk("bad0_rst", 32'(o_cpu_rst_n), 32'd0);
      start_load();
      send(8'(DEPTH + 1)); send(8'h00); send(8'h00); send(8'h00);
      chk("bad_big_error", 32'(o_load_error), 32'd1);

      // Abort mid-image, simultaneous start and byte, then reload
      start_load();
      send(8'h03); send(8'h00); send(8'h00); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
      step(1'b1, 1'b1, 8'h77, acc, rdy);
      chk("start_beats_byte", 32'(rdy), 32'd0);
      send(8'h01); send(8'h00); send(8'h00); send(8'h00);
      send(8'hef); send(8'hbe); send(8'had);
      chk("reload_not_yet", 32'(o_load_done), 32'd0);
      send(8'hde);
      chk("reload_done", 32'(o_load_done), 32'd1);
      i_pc = 32'd0; #1;
      chk("reload_word0", o_inst, 32'hdead_beef);
      start_load();
      chk("restart_drops_rst", 32'(o_cpu_rst_n), 32'd0);

      // Reset mid-word: word 1 must keep its old value
      start_load();
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55); send(8'h66); send(8'h77); send(8'h88);
      start_load();
      send(8'h02); send(8'h00); send(8'h00); send(8'h00);
      send(8'ha1); send(8'ha2); send(8'ha3); send(8'ha4);
      send(8'hc1); send(8'hc2);
      #2;
      i_rst_n = 1'b0;
      #1;
      m_status = 0;
      m_q.delete();
      chk("midrst_cpu_rst_n", 32'(o_cpu_rst_n), 32'd0);
      chk("midrst_ready", 32'(o_byte_ready), 32'd0);
      chk("midrst_done", 32'(o_load_done), 32'd0);
      step(1'b0, 1'b1, 8'hc3, acc, rdy);
      i_rst_n = 1'b1;
      check_fetch(32'd4);
      chk("midrst_word1", o_inst, 32'h8877_6655);
      check_fetch(32'd0);
      chk("midrst_word0", o_inst, 32'ha4a3_a2a1);

      // Maximum image, valid held high
      start_load();
      send(8'(DEPTH)); send(8'h00); send(8'h00); send(8'h00);
      for (int i = 0; i < 4 * DEPTH; i++) send(8'($urandom));
      chk("max_done", 32'(o_load_done), 32'd1);
      for (int i = 0; i < DEPTH; i++) check_fetch(32'(4 * i));

      // Randomized loads with backpressure and occasional aborts
      for (int it = 0; it < 8; it++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) hdr = 32'd0;
         else if (r == 1) hdr = 32'(DEPTH + 1);
         else if (r == 2) hdr = 32'hffff_fff0;
         else hdr = 32'($urandom_range(1, DEPTH));
         stream.delete();
         for (int b = 0; b < 4; b++) stream.push_back(hdr[8*b +: 8]);
         if (hdr >= 32'd1 && hdr <= 32'(DEPTH))
            for (int b = 0; b < 4 * int'(hdr); b++) stream.push_back(8'($urandom));
         step(1'b1, 1'($urandom), 8'($urandom), acc, rdy);
         idx = 0;
         budget = 0;
         while (m_status == 1 && budget < 3000) begin
            budget++;
            if ($urandom_range(0, 99) == 0) begin
               step(1'b1, 1'($urandom), 8'($urandom), acc, rdy);
               idx = 0;
            end else begin
               v = ($urandom_range(0, 2) != 0);
               step(1'b0, v, stream[idx], acc, rdy);
               if (acc) idx++;
            end
            check_fetch(32'($urandom_range(0, 4 * DEPTH + 7)));
         end
         chk("rand_load_terminated", 32'(m_status == 1), 32'd0);
      end
      for (int i = 0; i < DEPTH; i++) check_fetch(32'(4 * i));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
